// File: rtl/fsub_serial.sv
// Bit-serial full subtractor D = A - B - BIN, LSB first, with start/busy/done handshake.
// Optional signed-overflow output v_o is enabled by defining FSUB_SERIAL_OVF_EN.
`timescale 1ns / 1ps

module fsub_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o
`ifdef FSUB_SERIAL_OVF_EN
  ,
  output logic             v_o
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bor_q, bor_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef FSUB_SERIAL_OVF_EN
  logic             v_q, v_d;
`endif

  logic dbit;
  logic bor_next;
  logic last_bit;

  assign dbit     = a_q[0] ^ b_q[0] ^ bor_q;
  assign bor_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef FSUB_SERIAL_OVF_EN
    v_d     = v_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StShift;
          a_d     = a_i;
          b_d     = b_i;
          bor_d   = bin_i;
          cnt_d   = '0;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {dbit, r_q[WIDTH-1:1]};
        bor_d = bor_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_bit) begin
          state_d = StDone;
          d_d     = {dbit, r_q[WIDTH-1:1]};
          bout_d  = bor_next;
`ifdef FSUB_SERIAL_OVF_EN
          // Borrow into the MSB cell differs from borrow out of it.
          v_d     = bor_q ^ bor_next;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef FSUB_SERIAL_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef FSUB_SERIAL_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign busy_o = (state_q == StShift);
  assign done_o = (state_q == StDone);
  assign d_o    = d_q;
  assign bout_o = bout_q;
`ifdef FSUB_SERIAL_OVF_EN
  assign v_o    = v_q;
`endif

endmodule
